// File: rtl/div_pkg.sv
// Shared types and constants for the 8-by-4 sequential restoring divider.
package div_pkg;

  localparam int DW = 8;
  localparam int VW = 4;
  localparam int CW = $clog2(DW);

  localparam logic [DW-1:0] Q_DZ = 8'hFF;
  localparam logic [VW-1:0] R_DZ = 4'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// subtract the divisor if it fits, and report the resulting quotient bit.
module div_step
  import div_pkg::*;
(
  input  logic [VW:0]   r,
  input  logic          n_bit,
  input  logic [VW-1:0] d,
  output logic [VW:0]   r_next,
  output logic          q_bit
);

  logic [VW+1:0] r_wide;

  // NOTE: every output gets a default before the condition so no latch is inferred.
  always_comb begin
    r_wide = {r, n_bit};
    r_next = r_wide[VW:0];
    q_bit  = 1'b0;
    // The partial remainder stays below d, so the wide compare always sees r[VW]=0;
    // keeping it in the compare makes the unit safe for any input.
    if (r_wide >= {2'b00, d}) begin
      r_next = r_wide[VW:0] - {1'b0, d};
      q_bit  = 1'b1;
    end
  end

endmodule

// File: rtl/div8_by4_seq.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit
// per clock behind a start/ready/done handshake, with held result registers.
module div8_by4_seq
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] nq_q, nq_d;
  logic [VW-1:0] d_q, d_d;
  logic [VW:0]   r_q, r_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [VW:0]   step_r;
  logic          step_q_bit;

  div_step u_step (
    .r      (r_q),
    .n_bit  (nq_q[DW-1]),
    .d      (d_q),
    .r_next (step_r),
    .q_bit  (step_q_bit)
  );

  // nq_q is a combined shift register: dividend bits leave at the MSB while
  // quotient bits enter at the LSB, so after DW steps it holds the quotient.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nq_d    = nq_q;
    d_d     = d_q;
    r_d     = r_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          nq_d    = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (d_q == '0) begin
          // Zero divisor spends one cycle here so done lands one edge after acceptance.
          quo_d   = Q_DZ;
          rem_d   = R_DZ;
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          nq_d = {nq_q[DW-2:0], step_q_bit};
          r_d  = step_r;
          if (cnt_q == CW'(DW - 1)) begin
            quo_d   = {nq_q[DW-2:0], step_q_bit};
            rem_d   = step_r[VW-1:0];
            dz_d    = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nq_q    <= '0;
      d_q     <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nq_q    <= nq_d;
      d_q     <= d_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_div8_by4_seq.sv
// Self-checking bench for div8_by4_seq: vector table, protocol/reset sequences and
// an exhaustive sweep, all checked through a scoreboard popped on each done pulse.
module tb_div8_by4_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       ready, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  div8_by4_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         k;
    int         lat;
  } exp_t;

  exp_t sb[$];
  logic [7:0] last_q = '0;
  logic [3:0] last_r = '0;
  logic       last_dz = 1'b0;

  // Scoreboard consumer: every done pulse must match the oldest accepted operation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("done_without_op", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", int'(quotient), int'(e.q));
        check("remainder", int'(remainder), int'(e.r));
        check("div_by_zero", int'(div_by_zero), int'(e.dz));
        check("done_latency", cyc - e.k, e.lat);
        last_q  = e.q;
        last_r  = e.r;
        last_dz = e.dz;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", int'(ready), 1);
  endtask

  // Drives one start at a negedge where ready=1; the next rising edge (k) accepts it.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er, input logic edz);
    exp_t e;
    wait_ready();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q = eq; e.r = er; e.dz = edz; e.k = cyc + 1; e.lat = edz ? 1 : 8;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4, dz: 1'b0};
    vecs[1] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0, dz: 1'b0};
    vecs[2] = '{a: 8'd3,   b: 4'd15, q: 8'd0,   r: 4'd3, dz: 1'b0};
    vecs[3] = '{a: 8'd0,   b: 4'd9,  q: 8'd0,   r: 4'd0, dz: 1'b0};
    vecs[4] = '{a: 8'd15,  b: 4'd0,  q: 8'hFF,  r: 4'd0, dz: 1'b1};
    vecs[5] = '{a: 8'd100, b: 4'd10, q: 8'd10,  r: 4'd0, dz: 1'b0};
    vecs[6] = '{a: 8'd77,  b: 4'd5,  q: 8'd15,  r: 4'd2, dz: 1'b0};

    // Reset state
    #12;
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors, each followed by a ready-low and result-hold check mid-CALC
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
      if (!vecs[i].dz) begin
        repeat (3) @(negedge clk);
        check("ready_low_calc", int'(ready), 0);
        check("hold_quotient_calc", int'(quotient), int'(last_q));
        check("hold_dz_calc", int'(div_by_zero), int'(last_dz));
      end
      drain();
      check("ready_after_done", int'(ready), 1);
    end

    // Results persist in IDLE after done
    repeat (3) @(negedge clk);
    check("hold_quotient_idle", int'(quotient), int'(last_q));
    check("hold_remainder_idle", int'(remainder), int'(last_r));

    // Start pulse and operand changes during CALC are ignored
    run_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    dividend = 8'd255;
    divisor  = 4'd1;
    repeat (2) @(negedge clk);
    dividend = 8'd50;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dividend = 8'd9;
    divisor  = 4'd0;
    drain();
    repeat (12) @(negedge clk);
    check("no_queued_start", sb.size(), 0);

    // Start held high: back-to-back operations every 10 cycles
    wait_ready();
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    for (int j = 0; j < 3; j++) begin
      exp_t e;
      e.q = 8'd28; e.r = 4'd4; e.dz = 1'b0; e.k = cyc + 1 + 10 * j; e.lat = 8;
      sb.push_back(e);
    end
    repeat (21) @(posedge clk);
    #1 start = 1'b0;
    drain();

    // Divide-by-zero back-to-back with start held high: one op every 3 cycles
    wait_ready();
    dividend = 8'd15;
    divisor  = 4'd0;
    start    = 1'b1;
    for (int j = 0; j < 2; j++) begin
      exp_t e;
      e.q = 8'hFF; e.r = 4'd0; e.dz = 1'b1; e.k = cyc + 1 + 3 * j; e.lat = 1;
      sb.push_back(e);
    end
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    drain();
    run_op(8'd100, 4'd10, 8'd10, 4'd0, 1'b0);
    drain();

    // Reset during the 4th CALC cycle aborts without a done pulse
    wait_ready();
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_quotient_held", int'(quotient), 10);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", int'(ready), 1);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_quotient", int'(quotient), 0);
    check("mid_rst_remainder", int'(remainder), 0);
    check("mid_rst_dz", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_done_after_abort", sb.size(), 0);
    run_op(8'd77, 4'd5, 8'd15, 4'd2, 1'b0);
    drain();

    // Exhaustive sweep against an arithmetic reference
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
